// File: rtl/apb_req_pkg.sv
// Shared types and constants for the APB4 requester: FSM state enum, default widths
// and the strobe-width helper.
package apb_req_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_req_state_e;

    localparam int PROT_W     = 3;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/apb_requester_if.sv
// Command/response port and APB4 pins of the requester, bundled as one interface.
// master = the requester itself, slave = command source plus APB completer.
interface apb_requester_if
    import apb_req_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int DATA_WIDTH = DATA_W_DEF
) ();
    localparam int STRB_W = strb_width(DATA_WIDTH);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [STRB_W-1:0]     cmd_strb;
    logic [PROT_W-1:0]     cmd_prot;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [STRB_W-1:0]     PSTRB;
    logic [PROT_W-1:0]     PPROT;
    logic                  APBACTIVE;
    logic                  PREADY;
    logic                  PSLVERR;
    logic [DATA_WIDTH-1:0] PRDATA;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, APBACTIVE,
        input  PREADY, PSLVERR, PRDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, APBACTIVE,
        output PREADY, PSLVERR, PRDATA
    );

endinterface

// File: rtl/apb_req_wdog.sv
// ACCESS-phase watchdog: counts enabled wait cycles and flags when the limit is reached.
module apb_req_wdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (i_clear)
                r_cnt <= '0;
            else if (i_inc && !o_expired)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_requester.sv
// APB4 requester: single-transfer valid/ready command port in, IDLE/SETUP/ACCESS
// sequencing out. Define APB_REQ_TIMEOUT_EN to add the ACCESS-phase watchdog.
module apb_requester
    import apb_req_pkg::*;
#(
    parameter int ADDR_WIDTH     = ADDR_W_DEF,
    parameter int DATA_WIDTH     = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic             PCLK,
    input logic             PRESETn,
    input logic             PCLKEN,
    apb_requester_if.master bus
);
    localparam int STRB_W = strb_width(DATA_WIDTH);

    apb_req_state_e        r_state;
    logic                  r_psel, r_penable, r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata, r_rsp_rdata;
    logic [STRB_W-1:0]     r_pstrb;
    logic [PROT_W-1:0]     r_pprot;
    logic                  r_rsp_valid, r_rsp_err;
    logic                  w_cmd_ready, w_accept, w_timeout;

    // Back-to-back accept in the completing ACCESS cycle keeps PSEL high into the next SETUP.
    assign w_cmd_ready = PRESETn & PCLKEN &
                         ((r_state == IDLE) | ((r_state == ACCESS) & bus.PREADY));
    assign w_accept    = w_cmd_ready & bus.cmd_valid;

`ifdef APB_REQ_TIMEOUT_EN
    logic w_expired;
    logic r_rsp_timeout;

    apb_req_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .i_clk     (PCLK),
        .i_rst_n   (PRESETn),
        .i_en      (PCLKEN),
        .i_clear   (r_state == SETUP),
        .i_inc     ((r_state == ACCESS) & ~bus.PREADY),
        .o_expired (w_expired)
    );

    // PREADY wins over a coinciding expiry.
    assign w_timeout       = (r_state == ACCESS) & ~bus.PREADY & w_expired;
    assign bus.rsp_timeout = r_rsp_timeout;
`else
    logic w_unused_tmo;
    assign w_unused_tmo    = (TIMEOUT_CYCLES > 0);
    assign w_timeout       = 1'b0;
    assign bus.rsp_timeout = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state     <= IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
`ifdef APB_REQ_TIMEOUT_EN
            r_rsp_timeout <= 1'b0;
`endif
        end else if (PCLKEN) begin
            r_rsp_valid <= 1'b0;
`ifdef APB_REQ_TIMEOUT_EN
            r_rsp_timeout <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= SETUP;
                        r_psel  <= 1'b1;
                    end
                end
                SETUP: begin
                    r_state   <= ACCESS;
                    r_penable <= 1'b1;
                end
                ACCESS: begin
                    if (bus.PREADY) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= bus.PSLVERR;
                        r_rsp_rdata <= r_pwrite ? '0 : bus.PRDATA;
                        r_penable   <= 1'b0;
                        r_psel      <= w_accept;
                        r_state     <= w_accept ? SETUP : IDLE;
                    end else if (w_timeout) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_state     <= IDLE;
`ifdef APB_REQ_TIMEOUT_EN
                        r_rsp_timeout <= 1'b1;
`endif
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    // Address/data/control change only on accept; reads drive zero data and strobes.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
            r_pprot  <= '0;
        end else if (w_accept) begin
            r_pwrite <= bus.cmd_write;
            r_paddr  <= bus.cmd_addr;
            r_pwdata <= bus.cmd_write ? bus.cmd_wdata : '0;
            r_pstrb  <= bus.cmd_write ? bus.cmd_strb : '0;
            r_pprot  <= bus.cmd_prot;
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid & PCLKEN;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.PSEL      = r_psel;
    assign bus.PENABLE   = r_penable;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;
    assign bus.PSTRB     = r_pstrb;
    assign bus.PPROT     = r_pprot;
    assign bus.APBACTIVE = PRESETn & ((r_state != IDLE) | bus.cmd_valid);

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
- APB4 requester (master) FSM: the initiating end of the APB link whose completer side is modelled by the team's apb_intf driver.
- Accepts single transfers on a valid/ready command port and generates compliant IDLE/SETUP/ACCESS sequencing on PSEL/PENABLE.
- Waits on PREADY and returns PRDATA/PSLVERR as a one-cycle response.
- Sits behind the AHB-side bridge logic; its APB pins connect directly to the APB memory completer.

Parameters:
- ADDR_WIDTH, 16, PADDR and cmd_addr width
- DATA_WIDTH, 32, PWDATA/PRDATA width; must be 8, 16 or 32
- TIMEOUT_CYCLES, 256, ACCESS-phase wait limit; used only with APB_REQ_TIMEOUT_EN

Ports:
- PCLK  in  1  clock, all logic on rising edge
- PRESETn  in  1  synchronous active-low reset
- PCLKEN  in  1  clock enable; state advances only when high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted this cycle when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  DATA_WIDTH/8  write byte strobes
- cmd_prot  in  3  protection attributes
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_err  out  1  PSLVERR (or timeout) captured at completion
- rsp_timeout  out  1  completion was a timeout; tied 0 without macro
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PSTRB  out  DATA_WIDTH/8  APB strobes
- PPROT  out  3  APB protection
- APBACTIVE  out  1  bus-activity hint for clock gating
- PREADY, PSLVERR  in  1 each  completer handshake and error
- PRDATA  in  DATA_WIDTH  completer read data

Behaviour:
- Reset values: every registered output (all APB outputs, rsp_*) is 0 and state is IDLE. APBACTIVE and cmd_ready are forced to 0 while PRESETn is low.
- FSM states: IDLE, SETUP, ACCESS (package enum).
- PCLKEN = 0: registers hold; cmd_ready = 0; rsp_valid = 0.
- cmd_ready (combinational):
  - high when PCLKEN & state == IDLE;
  - high when PCLKEN & state == ACCESS & PREADY (back-to-back accept);
  - otherwise low.
- IDLE: on accept, latch cmd_* into APB registers and go to SETUP (PSEL = 1, PENABLE = 0). Accept-to-PSEL latency is 1 cycle.
- SETUP: next enabled edge unconditionally goes to ACCESS (PENABLE = 1). PREADY is ignored in SETUP.
- ACCESS, PREADY = 0: hold. PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB and PPROT stay stable.
- ACCESS, PREADY = 1: on the next edge:
  - rsp_valid = 1 for one cycle;
  - rsp_err = PSLVERR;
  - rsp_rdata = PRDATA for reads, 0 for writes;
  - PENABLE = 0;
  - if a command was accepted in the same cycle, go to SETUP with the new command (PSEL stays 1);
  - otherwise go to IDLE with PSEL = 0.
- Minimum transfer is 2 cycles; back-to-back throughput is 1 transfer per 2 cycles.
- Read transfers drive PSTRB = 0 and PWDATA = 0. Write transfers drive PSTRB = cmd_strb. A write with cmd_strb = 0 is legal and passed through.
- APBACTIVE = (state != IDLE) | cmd_valid.
- Response has no backpressure; consumers must sample rsp_valid.
- Reset mid-transfer: at the next edge with PRESETn = 0, go to IDLE, drop PSEL/PENABLE, and emit no response. The in-flight command is lost.
- The APB address/data/control registers update only on accept; they are never changed in SETUP or ACCESS.

Optional Feature:
- Macro: APB_REQ_TIMEOUT_EN.
- With the macro:
  - an ACCESS-cycle counter is cleared on SETUP->ACCESS and increments each enabled ACCESS cycle with PREADY = 0;
  - when the counter reaches TIMEOUT_CYCLES-1 without PREADY, the next edge emits rsp_valid = 1, rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0, drops PSEL/PENABLE and goes to IDLE;
  - cmd_ready stays low in that cycle;
  - if PREADY and the limit coincide, PREADY wins (normal completion).
- Without the macro: the requester waits indefinitely, rsp_timeout is tied 0, and no counter logic exists.

Decomposition:
- Package apb_req_pkg holds:
  - the apb_req_state_e enum {IDLE, SETUP, ACCESS};
  - PROT_W = 3;
  - defaults ADDR_W_DEF = 16 and DATA_W_DEF = 32;
  - a function for strobe width (DATA_WIDTH/8).
- One sub-module, apb_req_wdog (timeout counter and expiry flag), is instantiated only under APB_REQ_TIMEOUT_EN. The FSM and datapath remain in apb_requester.

Test Plan:
- Write, zero wait: cmd write addr 0x0040, wdata 0xDEADBEEF, strb 0xF, PREADY tied 1 -> PSEL at T+1, PENABLE at T+2; rsp_valid at T+3 with rsp_err = 0; PSTRB = 0xF throughout.
- Read, 3 wait states: addr 0x0100; PREADY low for 3 ACCESS cycles, then high with PRDATA = 0x12345678 -> APB signals stable for 4 ACCESS cycles; rsp_rdata = 0x12345678; PSTRB = 0.
- Back-to-back: two commands held valid -> second SETUP directly follows first ACCESS with PSEL continuously 1; two rsp_valid pulses 2 cycles apart.
- Error: PSLVERR = 1 with PREADY on a write to 0xFFFC -> rsp_err = 1, rsp_rdata = 0.
- PCLKEN gating and reset: drop PCLKEN for 5 cycles mid-ACCESS -> all outputs frozen. Then assert PRESETn = 0 mid-ACCESS -> next edge PSEL = 0, no rsp_valid, APBACTIVE = 0.
- Timeout (macro on, TIMEOUT_CYCLES = 8): PREADY held 0 -> after 8 ACCESS cycles, rsp_err = rsp_timeout = 1 and PSEL = 0.
